jt5205_ctrl: RTL and testbench

- Sample-playback sequencer in front of the jt5205 ADPCM decoder.
- Fetches ADPCM bytes from a ROM between a start and an end address, two nibbles per byte, high nibble first.
- Feeds one nibble per sample strobe to the decoder's din input.
- Holds the decoder in reset while idle.
- Provides start/stop control, busy status, a done pulse and underrun detection.

---
 rtl/jt5205_ctrl.sv | 139 +++++++++++++
 tb/tb_jt5205_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jt5205_ctrl.sv
// rtl/jt5205_ctrl.sv - ADPCM sample-playback sequencer feeding the jt5205 decoder
`timescale 1ns/1ps
module jt5205_ctrl #(
  parameter int AW = 18
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sample_stb,
  input  logic          start,
  input  logic          stop,
  input  logic [AW-1:0] start_addr,
  input  logic [AW-1:0] end_addr,
  output logic [AW-1:0] rom_addr,
  output logic          rom_cs,
  input  logic [7:0]    rom_data,
  input  logic          rom_ok,
  output logic [3:0]    din,
  output logic          adpcm_rst,
  output logic          busy,
  output logic          done,
  output logic          underrun
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] fetch_ptr, end_ptr;
  logic          fetch_left;   // bytes through end_ptr still to be fetched
  logic [7:0]    cur_byte, pre_byte;
  logic          cur_valid;    // cur holds at least one unplayed nibble
  logic          cur_hi;       // next nibble of cur is the high one
  logic          pre_valid;

  logic          abort, capture, load, stb_act, play_avail, play_hi;
  logic [7:0]    play_byte;

  // Start and stop both cancel whatever fetch is in flight
  assign abort      = start | stop;
  // Only a rom_ok seen while waiting on our own request is accepted
  assign capture    = (state == S_WAIT) && rom_cs && rom_ok && !abort;
  assign load       = busy && pre_valid && !cur_valid;
  assign stb_act    = sample_stb && busy && !abort;
  // A byte loaded this cycle is visible to a coincident strobe
  assign play_avail = cur_valid | load;
  assign play_hi    = load | cur_hi;
  assign play_byte  = load ? pre_byte : cur_byte;

  // Fetch FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Fetch FSM next-state: request only when pre is free and bytes remain
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (busy && !abort && !pre_valid && fetch_left) state_nxt = S_REQ;
      S_REQ:  state_nxt = abort ? S_IDLE : S_WAIT;
      S_WAIT: if (abort || capture) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Fetch FSM outputs: address tracks the fetch pointer, held until capture
  always_comb begin
    rom_cs   = (state != S_IDLE);
    rom_addr = fetch_ptr;
  end

  // Playback datapath: pointers, prefetch and current byte, decoder feed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_ptr  <= '0;
      end_ptr    <= '0;
      fetch_left <= 1'b0;
      cur_byte   <= 8'h00;
      cur_valid  <= 1'b0;
      cur_hi     <= 1'b1;
      pre_byte   <= 8'h00;
      pre_valid  <= 1'b0;
      din        <= 4'h0;
      adpcm_rst  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        fetch_ptr  <= start_addr;
        end_ptr    <= end_addr;
        fetch_left <= 1'b1;
        pre_valid  <= 1'b0;
        cur_valid  <= 1'b0;
        cur_hi     <= 1'b1;
        busy       <= 1'b1;
        adpcm_rst  <= 1'b1;
        underrun   <= 1'b0;
        din        <= 4'h0;
      end else if (stop) begin
        fetch_left <= 1'b0;
        pre_valid  <= 1'b0;
        cur_valid  <= 1'b0;
        busy       <= 1'b0;
        adpcm_rst  <= 1'b1;
        din        <= 4'h0;
      end else begin
        if (capture) begin
          pre_byte  <= rom_data;
          pre_valid <= 1'b1;
          fetch_ptr <= fetch_ptr + AW'(1);
          if (fetch_ptr == end_ptr) fetch_left <= 1'b0;
        end
        if (load) begin
          pre_valid <= 1'b0;
          cur_byte  <= pre_byte;
          cur_valid <= 1'b1;
          cur_hi    <= 1'b1;
          adpcm_rst <= 1'b0;
        end
        if (stb_act) begin
          if (play_avail) begin
            din       <= play_hi ? play_byte[7:4] : play_byte[3:0];
            cur_hi    <= ~play_hi;
            cur_valid <= play_hi;
          end else if (fetch_left) begin
            underrun <= 1'b1;
          end else begin
            busy      <= 1'b0;
            adpcm_rst <= 1'b1;
            din       <= 4'h0;
            done      <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_jt5205_ctrl.sv
// tb/tb_jt5205_ctrl.sv - scoreboard bench for jt5205_ctrl
`timescale 1ns/1ps
module tb_jt5205_ctrl;
  localparam int AW = 18;
  localparam int AMASK = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          sample_stb = 1'b0, start = 1'b0, stop = 1'b0;
  logic [AW-1:0] start_addr = '0, end_addr = '0;
  logic [AW-1:0] rom_addr;
  logic          rom_cs, rom_ok;
  logic [7:0]    rom_data;
  logic [3:0]    din;
  logic          adpcm_rst, busy, done, underrun;

  always #5 clk = ~clk;

  jt5205_ctrl #(.AW(AW)) dut (
    .clk(clk), .rst(rst), .sample_stb(sample_stb), .start(start), .stop(stop),
    .start_addr(start_addr), .end_addr(end_addr), .rom_addr(rom_addr),
    .rom_cs(rom_cs), .rom_data(rom_data), .rom_ok(rom_ok), .din(din),
    .adpcm_rst(adpcm_rst), .busy(busy), .done(done), .underrun(underrun)
  );

  // ROM model: answers rom_lat cycles after rom_cs rises; rogue injects stray acks
  logic [7:0] mem [0:(1<<AW)-1];
  int   rom_lat = 1;
  int   rom_cnt = 0;
  logic rogue = 1'b0;
  always @(posedge clk) rom_cnt <= rom_cs ? rom_cnt + 1 : 0;
  assign rom_ok   = (rom_cs && rom_cnt >= rom_lat) || rogue;
  assign rom_data = rogue ? 8'hEE : mem[rom_addr];

  int errors = 0;
  int checks = 0;
  logic [3:0] exp_q[$];
  logic [3:0] pend_q[$];
  logic [AW-1:0] pend_s, pend_e, cur_s, cur_e;
  int stb_cnt = 0, done_cnt = 0, done_stb = 0, fetch_cnt = 0;
  logic [3:0] last_nib = 4'h0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT behaviour at each negedge against the scoreboard
  logic p_stb = 0, p_busy = 0, p_start = 0, p_stop = 0, p_rst = 0, p_cs = 0;
  logic [3:0] p_din = 0;
  logic [3:0] mon_e;
  logic [AW-1:0] off_a, off_e;
  always @(negedge clk) begin
    if (!rst || !p_rst) begin
      exp_q.delete();
    end else if (p_start) begin
      exp_q = pend_q;
      cur_s = pend_s;
      cur_e = pend_e;
      stb_cnt = 0;
      fetch_cnt = 0;
      chk("start_busy", busy, 1);
      chk("start_underrun", underrun, 0);
      chk("start_adpcm_rst", adpcm_rst, 1);
      chk("start_rom_cs", rom_cs, 0);
    end else if (p_stop) begin
      exp_q.delete();
      chk("stop_busy", busy, 0);
      chk("stop_rom_cs", rom_cs, 0);
      chk("stop_adpcm_rst", adpcm_rst, 1);
      chk("stop_din", din, 0);
      chk("stop_done", done, 0);
    end else if (p_stb && p_busy) begin
      stb_cnt++;
      if (!busy) begin
        done_cnt++;
        done_stb = stb_cnt;
        chk("end_done", done, 1);
        chk("end_nibbles_left", exp_q.size(), 0);
        chk("end_din", din, 0);
        chk("end_adpcm_rst", adpcm_rst, 1);
      end else if (din != p_din) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_nibble: got %0h expected none at %0t", din, $time);
        end else begin
          mon_e = exp_q.pop_front();
          chk("nibble", din, mon_e);
          last_nib = mon_e;
        end
        chk("play_adpcm_rst", adpcm_rst, 0);
        chk("play_done", done, 0);
      end else begin
        chk("hold_underrun", underrun, 1);
      end
    end else begin
      chk("quiet_done", done, 0);
      chk("quiet_busy", busy, p_busy);
      chk("quiet_din", din, p_din);
    end
    if (rst && p_rst && rom_cs && !p_cs) begin
      fetch_cnt++;
      off_a = rom_addr - cur_s;
      off_e = cur_e - cur_s;
      chk("fetch_in_range", off_a <= off_e, 1);
      if (fetch_cnt == 1) chk("first_fetch_addr", rom_addr, cur_s);
    end
    p_stb = sample_stb; p_busy = busy; p_start = start; p_stop = stop;
    p_rst = rst; p_cs = rom_cs; p_din = din;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Random ROM contents: nonzero nibbles, never two equal in a row
  task automatic fill(input logic [AW-1:0] s, input int n, input logic [3:0] prev);
    logic [3:0] hi, lo;
    for (int i = 0; i < n; i++) begin
      do hi = 4'($urandom_range(1, 15)); while (hi == prev);
      do lo = 4'($urandom_range(1, 15)); while (lo == hi);
      mem[(int'(s) + i) & AMASK] = {hi, lo};
      prev = lo;
    end
  endtask

  // Expected playback order: every byte from s through e (wrapping), high nibble first
  task automatic issue_start(input logic [AW-1:0] s, input logic [AW-1:0] e);
    int n;
    logic [7:0] b;
    pend_q.delete();
    n = ((int'(e) - int'(s)) & AMASK) + 1;
    for (int i = 0; i < n; i++) begin
      b = mem[(int'(s) + i) & AMASK];
      pend_q.push_back(b[7:4]);
      pend_q.push_back(b[3:0]);
    end
    pend_s = s;
    pend_e = e;
    start_addr = s;
    end_addr = e;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run(input int per, input int budget);
    int d0 = done_cnt;
    for (int c = 1; c <= budget; c++) begin
      sample_stb = (c % per == 0);
      tick();
      sample_stb = 1'b0;
      if (done_cnt != d0) break;
    end
    sample_stb = 1'b0;
    tick();
    chk("done_seen", done_cnt != d0, 1);
  endtask

  task automatic strobe_until_pending(input int per, input bit need_underrun);
    for (int c = 1; c <= 300; c++) begin
      if (rom_cs && rom_cnt >= 5 && (!need_underrun || underrun)) break;
      sample_stb = (c % per == 0);
      tick();
      sample_stb = 1'b0;
    end
    chk("pending_request", rom_cs, 1);
  endtask

  initial begin
    logic [AW-1:0] s, e;
    int n, d0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_rom_cs", rom_cs, 0);
    chk("rst_din", din, 0);
    chk("rst_adpcm_rst", adpcm_rst, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_underrun", underrun, 0);
    rst = 1'b1;
    repeat (3) tick();

    // Fast ROM, two fixed bytes
    rom_lat = 1;
    mem[18'h00100] = 8'h12;
    mem[18'h00101] = 8'h34;
    issue_start(18'h00100, 18'h00101);
    run(8, 200);
    chk("t1_done_strobe", done_stb, 5);
    chk("t1_underrun", underrun, 0);
    chk("t1_fetches", fetch_cnt, 2);

    // Slow ROM forces underrun; order must still be preserved
    rom_lat = 20;
    fill(18'h01000, 3, 4'h0);
    issue_start(18'h01000, 18'h01002);
    run(4, 600);
    chk("t2_underrun", underrun, 1);

    // Stop with a request outstanding, then stray acks
    rom_lat = 20;
    fill(18'h02000, 4, 4'h0);
    d0 = done_cnt;
    issue_start(18'h02000, 18'h02003);
    strobe_until_pending(4, 1'b0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    rogue = 1'b1;
    for (int c = 0; c < 4; c++) begin
      sample_stb = (c == 1);
      tick();
    end
    sample_stb = 1'b0;
    rogue = 1'b0;
    repeat (3) tick();
    chk("t3_no_done", done_cnt, d0);
    chk("t3_din", din, 0);
    chk("t3_busy", busy, 0);
    chk("t3_adpcm_rst", adpcm_rst, 1);

    // Restart mid-playback while underrun and a fetch are pending
    rom_lat = 20;
    fill(18'h00100, 4, 4'h0);
    issue_start(18'h00100, 18'h00103);
    strobe_until_pending(4, 1'b1);
    rom_lat = 1;
    fill(18'h00200, 3, last_nib);
    issue_start(18'h00200, 18'h00202);
    run(8, 400);
    chk("t4_underrun", underrun, 0);
    chk("t4_done_strobe", done_stb, 7);

    // Single byte at the top of the address space
    mem[18'h3FFFF] = 8'hA5;
    issue_start(18'h3FFFF, 18'h3FFFF);
    run(8, 200);
    chk("t5_done_strobe", done_stb, 3);
    chk("t5_fetches", fetch_cnt, 1);

    // Wrap from the last address to zero
    fill(18'h3FFFF, 1, 4'h0);
    fill(18'h00000, 1, mem[18'h3FFFF][3:0]);
    issue_start(18'h3FFFF, 18'h00000);
    run(8, 200);
    chk("t6_done_strobe", done_stb, 5);
    chk("t6_fetches", fetch_cnt, 2);

    // Randomized playbacks
    for (int k = 0; k < 8; k++) begin
      s = AW'($urandom);
      n = $urandom_range(1, 5);
      e = AW'((int'(s) + n - 1) & AMASK);
      rom_lat = $urandom_range(1, 10);
      fill(s, n, 4'h0);
      issue_start(s, e);
      run($urandom_range(3, 12), 800);
      chk("rand_fetches", fetch_cnt, n);
    end

    // Asynchronous reset mid-playback
    rom_lat = 1;
    fill(18'h00300, 6, 4'h0);
    issue_start(18'h00300, 18'h00305);
    for (int c = 1; c <= 20; c++) begin
      sample_stb = (c % 4 == 0);
      tick();
    end
    sample_stb = 1'b0;
    chk("t7_busy_before", busy, 1);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_rom_addr", rom_addr, 0);
    chk("arst_rom_cs", rom_cs, 0);
    chk("arst_din", din, 0);
    chk("arst_adpcm_rst", adpcm_rst, 1);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_underrun", underrun, 0);
    tick();
    rst = 1'b1;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
